// File: rtl/bpm_window_sequencer.sv
// rtl/bpm_window_sequencer.sv - heartbeat pulse counting window sequencer
//
// Synchronizes the raw heartbeat line, detects rising edges and counts them
// over a fixed window of CLK_DIV*WINDOW_SEC cycles. Each completed window
// delivers a saturated 8-bit count over a valid/ready handshake. Windows are
// single-shot or back-to-back (continuous), can be aborted with stop, and a
// sticky overrun flag reports results overwritten before acceptance.
//
// Optional feature macro: BPM_SEQ_DEBOUNCE_EN inserts a level debounce
// filter (DEBOUNCE_CYC stable cycles) between the synchronizer and the edge
// register. Without the macro every synchronized rising edge counts.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   begin a window (sampled in IDLE only)
//   stop         in   abort the window / continuous sequence
//   continuous   in   latched with start; repeat windows until stop
//   pulse_in     in   raw asynchronous heartbeat pulse
//   pulse_count  out  [7:0] count of the last completed window
//   count_valid  out  pulse_count holds a result not yet accepted
//   count_ready  in   downstream accepts the result
//   busy         out  high while a window is being counted
//   overrun      out  sticky: a result was overwritten before acceptance
`timescale 1ns/1ps

module bpm_window_sequencer #(
    parameter int unsigned CLK_DIV      = 1_000_000,
    parameter int unsigned WINDOW_SEC   = 10,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    input  logic       pulse_in,
    output logic [7:0] pulse_count,
    output logic       count_valid,
    input  logic       count_ready,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned W      = CLK_DIV * WINDOW_SEC;
    localparam int unsigned WCW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [WCW-1:0] W_LAST = WCW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchronizer, optional debounce, edge register
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic level;
    logic prev;
    logic pulse_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
        end
    end

`ifdef BPM_SEQ_DEBOUNCE_EN
    localparam int unsigned DCW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYC - 1);

    logic [DCW-1:0] deb_cnt;
    logic           deb_level;

    // The filtered level follows sync2 only after sync2 has disagreed with
    // it for DEBOUNCE_CYC consecutive cycles; any agreement restarts the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (sync2 != deb_level) begin
            if (deb_cnt == DEB_LAST) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign level = deb_level;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign pulse_edge = level & ~prev;

    // ------------------------------------------------------------------
    // Accumulator next value: saturates at 255 instead of wrapping
    // ------------------------------------------------------------------
    logic [7:0] acc;
    logic [7:0] acc_next;

    always_comb begin
        acc_next = acc;
        if (pulse_edge && (acc != 8'hFF)) begin
            acc_next = acc + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Window FSM with registered outputs
    // ------------------------------------------------------------------
    state_t         state;
    logic [WCW-1:0] wcnt;
    logic           cont_lat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wcnt        <= '0;
            acc         <= '0;
            cont_lat    <= 1'b0;
            pulse_count <= '0;
            count_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Handshake retires the result; a window ending in this same
            // cycle re-asserts count_valid below (last assignment wins).
            if (count_valid && count_ready) begin
                count_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= COUNT;
                        busy     <= 1'b1;
                        wcnt     <= '0;
                        acc      <= '0;
                        cont_lat <= continuous;
                        overrun  <= 1'b0;
                    end
                end

                COUNT: begin
                    if (stop) begin
                        // Abort wins over a coincident window end; the
                        // partial count is discarded.
                        state <= IDLE;
                        busy  <= 1'b0;
                        wcnt  <= '0;
                        acc   <= '0;
                    end else if (wcnt == W_LAST) begin
                        // acc_next folds in an edge detected on the final
                        // cycle so nothing is lost at the boundary.
                        pulse_count <= acc_next;
                        count_valid <= 1'b1;
                        if (count_valid && !count_ready) begin
                            overrun <= 1'b1;
                        end
                        if (cont_lat) begin
                            wcnt <= '0;
                            acc  <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        acc  <= acc_next;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
